// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit accesses (low half, then high half)
// on an external asynchronous SRAM, holding ready low until the word access retires.
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;

  localparam int unsigned        CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [17:0]       sram_addr_q, sram_addr_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;

  logic [16:0]       word;
  logic              cnt_last;
  logic              access_d;
  logic              dq_drive;
  logic [15:0]       dq_out;

  assign word     = 17'((address - BASE_ADDR) >> 2);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = '0;
    read_data_d = read_data_q;
    ready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = ~wr_en & ~rd_en;
        if (wr_en | rd_en) begin
          state_d = S_LOW;
          op_d    = wr_en ? OP_WRITE : OP_READ;
        end
      end
      S_LOW: begin
        if (cnt_last) begin
          state_d = S_HIGH;
          if (op_q == OP_READ) read_data_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_last) begin
          state_d = S_DONE;
          if (op_q == OP_READ) read_data_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are derived from the next state/count to line up with the phase.
    access_d    = (state_d == S_LOW) || (state_d == S_HIGH);
    sram_addr_d = access_d ? {word, state_d == S_HIGH} : sram_addr_q;
    we_n_d      = ~(access_d && (op_d == OP_WRITE) && (cnt_d != '0));
    oe_n_d      = ~(access_d && (op_d == OP_READ));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      cnt_q       <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign dq_drive = (op_q == OP_WRITE) && ((state_q == S_LOW) || (state_q == S_HIGH));
  assign dq_out   = (state_q == S_HIGH) ? writeData[31:16] : writeData[15:0];
  assign SRAM_DQ  = dq_drive ? dq_out : 16'bz;

  assign readData  = read_data_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
